ahb_rr_arbiter: RTL and testbench

//  Round-robin arbiter and address/data multiplexer placing NUM_MST AHB masters in front of the single AHB-to-APB bridge slave port.

---
 rtl/ahb_rr_arbiter_if.sv | 46 ++++
 rtl/ahb_rr_arbiter.sv | 109 ++++++++++
 tb/tb_ahb_rr_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ahb_rr_arbiter_if.sv
// Bus bundle between NUM_MST AHB masters, the round-robin arbiter and the
// AHB-to-APB bridge slave port.
// Ports: Hbusreq, Haddr_m, Htrans_m, Hwrite_m, Hwdata_m (master side),
//        Hready_in (bridge), Hgrant, Hmaster, Hmaster_d, Haddr, Htrans,
//        Hwrite, Hwdata (arbiter outputs).
// Optional: ARB_LOCK_EN adds Hlock_m.
interface ahb_rr_arbiter_if #(
    parameter int NUM_MST = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    localparam int MW = $clog2(NUM_MST);

    logic [NUM_MST-1:0]        Hbusreq;
    logic [NUM_MST*ADDR_W-1:0] Haddr_m;
    logic [NUM_MST*2-1:0]      Htrans_m;
    logic [NUM_MST-1:0]        Hwrite_m;
    logic [NUM_MST*DATA_W-1:0] Hwdata_m;
    logic                      Hready_in;
`ifdef ARB_LOCK_EN
    logic [NUM_MST-1:0]        Hlock_m;
`endif
    logic [NUM_MST-1:0]        Hgrant;
    logic [MW-1:0]             Hmaster;
    logic [MW-1:0]             Hmaster_d;
    logic [ADDR_W-1:0]         Haddr;
    logic [1:0]                Htrans;
    logic                      Hwrite;
    logic [DATA_W-1:0]         Hwdata;

    modport slave (
`ifdef ARB_LOCK_EN
        input  Hlock_m,
`endif
        input  Hbusreq, Haddr_m, Htrans_m, Hwrite_m, Hwdata_m, Hready_in,
        output Hgrant, Hmaster, Hmaster_d, Haddr, Htrans, Hwrite, Hwdata
    );

    modport master (
`ifdef ARB_LOCK_EN
        output Hlock_m,
`endif
        output Hbusreq, Haddr_m, Htrans_m, Hwrite_m, Hwdata_m, Hready_in,
        input  Hgrant, Hmaster, Hmaster_d, Haddr, Htrans, Hwrite, Hwdata
    );
endinterface

// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB arbiter and address/write-data mux in front of the single
// AHB-to-APB bridge slave port.
// Ports: Hclk, Hresetn (async active-low), bus (ahb_rr_arbiter_if.slave).
// Macro ARB_LOCK_EN: owner's Hlock_m suppresses re-arbitration.
module ahb_rr_arbiter #(
    parameter int NUM_MST  = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    ahb_rr_arbiter_if.slave   bus
);
    localparam int MW = $clog2(NUM_MST);
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

    typedef enum logic {ST_PARK, ST_OWN} state_t;

    state_t          r_state, w_state_nxt;
    logic [MW-1:0]   r_master, w_master_nxt;
    logic [MW-1:0]   r_master_d;
    logic [HW-1:0]   r_hold, w_hold_nxt;

    logic [NUM_MST-1:0] w_own_oh;
    logic [1:0]         w_htrans;
    logic               w_accept;
    logic               w_others;
    logic               w_own_req;
    logic               w_lock;
    logic               w_rearb;
    logic               w_found;
    logic [MW-1:0]      w_pick;

    assign w_own_oh  = NUM_MST'(1) << r_master;
    assign w_htrans  = (r_state == ST_OWN) ?
                       bus.Htrans_m[int'(r_master)*2 +: 2] : 2'b00;
    assign w_accept  = bus.Hready_in & w_htrans[1];
    assign w_others  = |(bus.Hbusreq & ~w_own_oh);
    assign w_own_req = bus.Hbusreq[r_master];

`ifdef ARB_LOCK_EN
    assign w_lock = (r_state == ST_OWN) & bus.Hlock_m[r_master];
`else
    assign w_lock = 1'b0;
`endif

    // Owner gave up the bus, or used its quota while someone else waits.
    assign w_rearb = ~w_lock &
                     (~w_own_req |
                      ((r_hold == HOLD_MAX) & w_accept & w_others));

    // Rotating search starting just after the current owner; the owner
    // itself is visited last.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_master;
        for (int k = 1; k <= NUM_MST; k++) begin
            if (!w_found &&
                bus.Hbusreq[(int'(r_master) + k) % NUM_MST]) begin
                w_found = 1'b1;
                w_pick  = MW'((int'(r_master) + k) % NUM_MST);
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_master_nxt = r_master;
        w_hold_nxt   = r_hold;
        if (w_rearb) begin
            if (w_found) begin
                w_state_nxt  = ST_OWN;
                w_master_nxt = w_pick;
            end else begin
                w_state_nxt  = ST_PARK;
            end
        end else begin
            w_state_nxt = ST_OWN;
        end
        if (w_state_nxt == ST_PARK || w_master_nxt != r_master)
            w_hold_nxt = '0;
        else if (w_accept && r_hold != HOLD_MAX)
            w_hold_nxt = r_hold + 1'b1;
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_state    <= ST_PARK;
            r_master   <= '0;
            r_master_d <= '0;
            r_hold     <= '0;
        end else if (bus.Hready_in) begin
            r_state    <= w_state_nxt;
            r_master   <= w_master_nxt;
            r_master_d <= r_master;
            r_hold     <= w_hold_nxt;
        end
    end

    assign bus.Hgrant    = w_own_oh;
    assign bus.Hmaster   = r_master;
    assign bus.Hmaster_d = r_master_d;
    assign bus.Htrans    = w_htrans;
    assign bus.Haddr     = bus.Haddr_m[int'(r_master)*ADDR_W +: ADDR_W];
    assign bus.Hwrite    = bus.Hwrite_m[r_master];
    assign bus.Hwdata    = bus.Hwdata_m[int'(r_master_d)*DATA_W +: DATA_W];
endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Self-checking bench for ahb_rr_arbiter: transaction-level model compared
// every cycle plus directed literal expectations.
module tb_ahb_rr_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MH = 8;

    logic Hclk    = 1'b0;
    logic Hresetn = 1'b0;
    always #5 Hclk = ~Hclk;

    ahb_rr_arbiter_if #(.NUM_MST(N), .ADDR_W(AW), .DATA_W(DW)) bus();

    ahb_rr_arbiter #(
        .NUM_MST(N), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)
    ) dut (
        .Hclk(Hclk),
        .Hresetn(Hresetn),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Model: who owns the bus, whether parked, transfers accepted this tenure.
    int m_owner   = 0;
    int m_owner_d = 0;
    int m_acc     = 0;
    bit m_park    = 1'b1;
    logic t_xfer, t_rival, t_lock;
    int   t_acc, t_nxt;

    function automatic int next_req(input int from, input logic [N-1:0] req);
        for (int k = 1; k <= N; k++)
            if (req[(from + k) % N]) return (from + k) % N;
        return -1;
    endfunction

    always @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            m_owner = 0; m_owner_d = 0; m_acc = 0; m_park = 1'b1;
        end else if (bus.Hready_in) begin
            t_xfer  = !m_park && bus.Htrans_m[2*m_owner+1];
            t_rival = (bus.Hbusreq & ~(N'(1) << m_owner)) != 0;
            t_lock  = 1'b0;
`ifdef ARB_LOCK_EN
            t_lock  = !m_park && bus.Hlock_m[m_owner];
`endif
            t_acc     = m_acc + (t_xfer ? 1 : 0);
            m_owner_d = m_owner;
            if (t_lock || (bus.Hbusreq[m_owner] &&
                           !(t_xfer && t_acc >= MH && t_rival))) begin
                m_park = 1'b0;
                m_acc  = t_acc;
            end else begin
                t_nxt = next_req(m_owner, bus.Hbusreq);
                m_acc = 0;
                if (t_nxt < 0) begin
                    m_park = 1'b1;
                end else begin
                    m_park  = 1'b0;
                    m_owner = t_nxt;
                end
            end
        end
    end

    always @(negedge Hclk) begin
        chk("grant", bus.Hgrant, N'(1) << m_owner);
        chk("hmaster", bus.Hmaster, m_owner);
        chk("hmaster_d", bus.Hmaster_d, m_owner_d);
        chk("htrans", bus.Htrans,
            m_park ? 2'b00 : bus.Htrans_m[2*m_owner +: 2]);
        chk("haddr", bus.Haddr, 32'h20 * m_owner);
        chk("hwrite", bus.Hwrite, bus.Hwrite_m[m_owner]);
        chk("hwdata", bus.Hwdata, 32'hA5A5_0000 + m_owner_d);
    end

    task automatic step(input int n);
        repeat (n) @(posedge Hclk);
        #1;
    endtask

    initial begin
        bus.Hready_in = 1'b1;
        bus.Hbusreq   = '0;
        bus.Htrans_m  = '0;
        bus.Hwrite_m  = 4'b0101;
`ifdef ARB_LOCK_EN
        bus.Hlock_m   = '0;
`endif
        for (int i = 0; i < N; i++) begin
            bus.Haddr_m[i*AW +: AW]  = 32'h20 * i;
            bus.Hwdata_m[i*DW +: DW] = 32'hA5A5_0000 + i;
        end
        step(2);
        chk("rst_grant", bus.Hgrant, 4'b0001);
        chk("rst_master", bus.Hmaster, 0);
        chk("rst_htrans", bus.Htrans, 2'b00);

        Hresetn = 1'b1;
        bus.Htrans_m = 8'hAA;
        step(3);
        chk("park_htrans", bus.Htrans, 2'b00);
        chk("park_grant", bus.Hgrant, 4'b0001);

        bus.Hbusreq = 4'b1010;
        step(1);
        chk("req_first", bus.Hmaster, 1);
        chk("req_grant1", bus.Hgrant, 4'b0010);
        bus.Hbusreq = 4'b1000;
        step(1);
        chk("req_second", bus.Hmaster, 3);
        bus.Hbusreq = 4'b0010;
        step(1);
        chk("req_third", bus.Hmaster, 1);
        bus.Hbusreq = 4'b0000;
        step(1);
        chk("drop_park_htrans", bus.Htrans, 2'b00);
        chk("drop_park_grant", bus.Hgrant, 4'b0010);

        bus.Hbusreq = 4'b1111;
        step(1);
        chk("rot_start", bus.Hmaster, 1);
        step(7);
        chk("rot_hold7", bus.Hmaster, 1);
        step(1);
        chk("rot_to2", bus.Hmaster, 2);
        step(8);
        chk("rot_to3", bus.Hmaster, 3);
        step(8);
        chk("rot_to0", bus.Hmaster, 0);
        step(8);
        chk("rot_to1", bus.Hmaster, 1);
        step(8);
        chk("rot_to2b", bus.Hmaster, 2);
        chk("ho_wdata", bus.Hwdata, 32'hA5A5_0001);

        bus.Hready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("ws_grant", bus.Hgrant, 4'b0100);
            chk("ws_master", bus.Hmaster, 2);
            chk("ws_master_d", bus.Hmaster_d, 1);
            chk("ws_wdata", bus.Hwdata, 32'hA5A5_0001);
        end
        bus.Hready_in = 1'b1;
        step(1);
        chk("ws_release_d", bus.Hmaster_d, 2);
        chk("ws_release_wd", bus.Hwdata, 32'hA5A5_0002);

        chk("pipe_addr2", bus.Haddr, 32'h0000_0040);
        bus.Hbusreq = 4'b0001;
        step(1);
        chk("pipe_master", bus.Hmaster, 0);
        chk("pipe_addr0", bus.Haddr, 32'h0);
        chk("pipe_wdata", bus.Hwdata, 32'hA5A5_0002);
        step(1);
        chk("pipe_wdata0", bus.Hwdata, 32'hA5A5_0000);

        bus.Hbusreq  = 4'b1111;
        bus.Htrans_m = 8'h00;
        step(12);
        chk("idle_norot", bus.Hmaster, 0);
        bus.Htrans_m = 8'hAA;
        step(6);
        chk("quota_edge", bus.Hmaster, 0);
        step(1);
        chk("quota_rot", bus.Hmaster, 1);

        bus.Hbusreq = 4'b0010;
        step(20);
        chk("single_keep", bus.Hmaster, 1);

        bus.Hbusreq = 4'b1000;
        step(1);
        chk("pre_rst", bus.Hmaster, 3);
        Hresetn = 1'b0;
        #1;
        chk("arst_grant", bus.Hgrant, 4'b0001);
        chk("arst_master", bus.Hmaster, 0);
        chk("arst_master_d", bus.Hmaster_d, 0);
        chk("arst_htrans", bus.Htrans, 2'b00);
        step(1);
        Hresetn = 1'b1;
        bus.Hbusreq = 4'b0000;
        step(2);
        chk("post_rst_htrans", bus.Htrans, 2'b00);

`ifdef ARB_LOCK_EN
        bus.Hbusreq = 4'b0010;
        step(1);
        chk("lock_own", bus.Hmaster, 1);
        bus.Hlock_m = 4'b0010;
        bus.Hbusreq = 4'b1111;
        step(20);
        chk("lock_hold", bus.Hmaster, 1);
        bus.Hlock_m = 4'b0000;
        step(1);
        chk("lock_drop", bus.Hmaster, 2);
`endif

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
